// File: rtl/jtvigil_gfxarb.sv
`default_nettype none
// ============================================================================
// Module   : jtvigil_gfxarb
// Brief    : Round-robin arbiter that shares one 32-bit SDRAM read port
//            among the scroll 1, scroll 2 and object ROM fetchers. Each
//            fetcher has a one-word cache (tag/data/valid) and a registered ok.
// Revision : 1.0 - initial release
// ============================================================================
module jtvigil_gfxarb #(
  parameter logic [21:0] SCR1_OFFSET = 22'h00000,
  parameter logic [21:0] SCR2_OFFSET = 22'h08000,
  parameter logic [21:0] OBJ_OFFSET  = 22'h10000,
  parameter logic [7:0]  TOUT        = 8'd255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        scr1_cs,
  input  logic [16:0] scr1_addr,
  output logic [31:0] scr1_data,
  output logic        scr1_ok,
  input  logic        scr2_cs,
  input  logic [17:0] scr2_addr,
  output logic [31:0] scr2_data,
  output logic        scr2_ok,
  input  logic        obj_cs,
  input  logic [17:0] obj_addr,
  output logic [31:0] obj_data,
  output logic        obj_ok,
  output logic [21:0] sdram_addr,
  output logic        sdram_req,
  input  logic        sdram_ack,
  input  logic        sdram_dok,
  input  logic [31:0] sdram_din,
  output logic        timeout
);

  localparam int         NCH     = 3;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;

  // Channel index following c in the ring scr1 -> scr2 -> obj -> scr1
  function automatic logic [1:0] next_ch(input logic [1:0] c);
    return (c == 2'd2) ? 2'd0 : c + 2'd1;
  endfunction

  // Channel k positions after pointer p, modulo the channel count
  function automatic logic [1:0] rr_idx(input logic [1:0] p, input int k);
    logic [2:0] s;
    s = {1'b0, p} + 3'(k);
    if (s >= 3'd3) s = s - 3'd3;
    return s[1:0];
  endfunction

  // SDRAM word offset of each channel's ROM region
  function automatic logic [21:0] chan_offset(input logic [1:0] c);
    case (c)
      2'd0:    return SCR1_OFFSET;
      2'd1:    return SCR2_OFFSET;
      default: return OBJ_OFFSET;
    endcase
  endfunction

  logic [1:0]     state_q, state_d;
  logic [1:0]     ptr_q, ptr_d;
  logic [1:0]     gnt_q, gnt_d;
  logic [17:0]    lat_q, lat_d;
  logic [21:0]    sdram_addr_q, sdram_addr_d;
  logic [7:0]     cnt_q, cnt_d;
  logic           timeout_q, timeout_d;

  logic [NCH-1:0] cs_w;
  logic [17:0]    addr_w [NCH];
  logic [NCH-1:0] pend_w;
  logic [NCH-1:0] ok_w;
  logic [31:0]    data_w [NCH];
  logic           any_pend_w;
  logic [1:0]     sel_w;
  logic           dok_w;
  logic           tout_w;
  logic           done_w;
  logic           wr_en_w;

  // scr1 is one bit narrower; zero-extend so every channel compares alike
  assign cs_w      = {obj_cs, scr2_cs, scr1_cs};
  assign addr_w[0] = {1'b0, scr1_addr};
  assign addr_w[1] = scr2_addr;
  assign addr_w[2] = obj_addr;

  // Data accepted from SDRAM: in WAIT, or together with the ack in REQ
  assign dok_w   = sdram_dok & ((state_q == ST_WAIT) | ((state_q == ST_REQ) & sdram_ack));
  // Abandon on the TOUT-th WAIT cycle unless data arrives in that same cycle
  assign tout_w  = (state_q == ST_WAIT) & ~sdram_dok & (cnt_q == TOUT - 8'd1);
  assign done_w  = dok_w | tout_w;
  // Only fill the cache if the requester still wants the fetched address
  assign wr_en_w = dok_w & (addr_w[gnt_q] == lat_q);

  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_ch
      localparam logic [1:0] IDX = 2'(gi);
      logic [17:0] tag_q;
      logic [31:0] data_q;
      logic        valid_q;
      logic        ok_q;

      assign pend_w[gi] = cs_w[gi] & (~valid_q | (tag_q != addr_w[gi]));
      assign ok_w[gi]   = ok_q;
      assign data_w[gi] = data_q;

      // Cache fill for the granted channel; ok registers a hit on the live address
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          tag_q   <= '0;
          data_q  <= '0;
          valid_q <= 1'b0;
          ok_q    <= 1'b0;
        end else begin
          if (wr_en_w && (gnt_q == IDX)) begin
            tag_q   <= lat_q;
            data_q  <= sdram_din;
            valid_q <= 1'b1;
          end
          ok_q <= cs_w[gi] & valid_q & (tag_q == addr_w[gi]);
        end
      end
    end
  endgenerate

  // First pending channel at or after the pointer (k=0 is checked last so it wins)
  always_comb begin
    any_pend_w = 1'b0;
    sel_w      = ptr_q;
    for (int k = NCH - 1; k >= 0; k--) begin
      if (pend_w[rr_idx(ptr_q, k)]) begin
        any_pend_w = 1'b1;
        sel_w      = rr_idx(ptr_q, k);
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (any_pend_w) state_d = ST_REQ;
      ST_REQ:  if (sdram_ack)  state_d = sdram_dok ? ST_IDLE : ST_WAIT;
      ST_WAIT: if (done_w)     state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Transfer bookkeeping: grant latch, bus address, wait counter, pointer, flag
  always_comb begin
    gnt_d        = gnt_q;
    lat_d        = lat_q;
    sdram_addr_d = sdram_addr_q;
    cnt_d        = cnt_q;
    ptr_d        = ptr_q;
    timeout_d    = timeout_q;
    if ((state_q == ST_IDLE) && any_pend_w) begin
      gnt_d        = sel_w;
      lat_d        = addr_w[sel_w];
      sdram_addr_d = {4'd0, addr_w[sel_w]} + chan_offset(sel_w);
    end
    if (state_q == ST_REQ)       cnt_d = '0;
    else if (state_q == ST_WAIT) cnt_d = cnt_q + 8'd1;
    if (done_w) ptr_d     = next_ch(gnt_q);
    if (tout_w) timeout_d = 1'b1;
  end

  // Transfer bookkeeping registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_q        <= '0;
      lat_q        <= '0;
      sdram_addr_q <= '0;
      cnt_q        <= '0;
      ptr_q        <= '0;
      timeout_q    <= 1'b0;
    end else begin
      gnt_q        <= gnt_d;
      lat_q        <= lat_d;
      sdram_addr_q <= sdram_addr_d;
      cnt_q        <= cnt_d;
      ptr_q        <= ptr_d;
      timeout_q    <= timeout_d;
    end
  end

  // FSM outputs and cache read-out
  always_comb begin
    sdram_req  = (state_q == ST_REQ);
    sdram_addr = sdram_addr_q;
    timeout    = timeout_q;
    scr1_data  = data_w[0];
    scr2_data  = data_w[1];
    obj_data   = data_w[2];
    scr1_ok    = ok_w[0];
    scr2_ok    = ok_w[1];
    obj_ok     = ok_w[2];
  end

endmodule
`default_nettype wire

// File: tb/tb_jtvigil_gfxarb.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_jtvigil_gfxarb
// Brief    : Self-checking bench for jtvigil_gfxarb with an SDRAM model and
//            an expected-address scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_jtvigil_gfxarb;

  localparam logic [21:0] S1OFF  = 22'h00000;
  localparam logic [21:0] S2OFF  = 22'h08000;
  localparam logic [21:0] OBOFF  = 22'h3C0001;
  localparam logic [7:0]  TOUT_B = 8'd255;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        scr1_cs = 1'b0, scr2_cs = 1'b0, obj_cs = 1'b0;
  logic [16:0] scr1_addr = '0;
  logic [17:0] scr2_addr = '0, obj_addr = '0;
  logic [31:0] scr1_data, scr2_data, obj_data;
  logic        scr1_ok, scr2_ok, obj_ok;
  logic [21:0] sdram_addr;
  logic        sdram_req;
  logic        sdram_ack, sdram_dok;
  logic [31:0] sdram_din;
  logic        timeout;

  int          vec = 0;
  int          errs = 0;

  // SDRAM model controls and scoreboard
  int          ack_dly = 1;
  int          dok_dly = 2;
  bit          dok_en = 1'b1;
  bit          ovr_en = 1'b0;
  logic [31:0] ovr_val = '0;
  int          m_st = 0;
  int          m_cnt = 0;
  int          nreq = 0;
  logic [21:0] req_addr = '0;
  logic [21:0] exp_q [$];

  jtvigil_gfxarb #(
    .SCR1_OFFSET(S1OFF),
    .SCR2_OFFSET(S2OFF),
    .OBJ_OFFSET (OBOFF),
    .TOUT       (TOUT_B)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .scr1_cs   (scr1_cs),
    .scr1_addr (scr1_addr),
    .scr1_data (scr1_data),
    .scr1_ok   (scr1_ok),
    .scr2_cs   (scr2_cs),
    .scr2_addr (scr2_addr),
    .scr2_data (scr2_data),
    .scr2_ok   (scr2_ok),
    .obj_cs    (obj_cs),
    .obj_addr  (obj_addr),
    .obj_data  (obj_data),
    .obj_ok    (obj_ok),
    .sdram_addr(sdram_addr),
    .sdram_req (sdram_req),
    .sdram_ack (sdram_ack),
    .sdram_dok (sdram_dok),
    .sdram_din (sdram_din),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] sdata(input logic [21:0] a);
    return {a[9:0], a} ^ 32'hC3A596F0;
  endfunction

  function automatic logic get_ok(input int ch);
    case (ch)
      0:       return scr1_ok;
      1:       return scr2_ok;
      default: return obj_ok;
    endcase
  endfunction

  // SDRAM model: acks ack_dly cycles after a request appears, returns data
  // dok_dly cycles after the ack; checks every request against the scoreboard
  initial begin
    logic [21:0] e;
    sdram_ack = 1'b0;
    sdram_dok = 1'b0;
    sdram_din = '0;
    forever begin
      @(negedge clk);
      sdram_ack = 1'b0;
      sdram_dok = 1'b0;
      if (!rst_n) begin
        m_st = 0;
      end else begin
        if (m_st == 2 && sdram_req) m_st = 0;
        if (m_st == 0 && sdram_req) begin
          req_addr = sdram_addr;
          nreq++;
          vec++;
          if (exp_q.size() == 0) begin
            errs++;
            $display("FAIL sb_unexpected_req: got addr %h, expected no request", sdram_addr);
          end else begin
            e = exp_q.pop_front();
            if (sdram_addr !== e) begin
              errs++;
              $display("FAIL sb_req_addr: got %h, expected %h", sdram_addr, e);
            end
          end
          m_cnt = 0;
          m_st  = 1;
        end
        if (m_st == 1) begin
          if (m_cnt >= ack_dly) begin
            sdram_ack = 1'b1;
            m_cnt     = 0;
            m_st      = 2;
            if (dok_dly == 0 && dok_en) begin
              sdram_dok = 1'b1;
              sdram_din = ovr_en ? ovr_val : sdata(req_addr);
              m_st      = 0;
            end
          end else begin
            m_cnt++;
          end
        end else if (m_st == 2) begin
          m_cnt++;
          if (dok_en && m_cnt == dok_dly) begin
            sdram_dok = 1'b1;
            sdram_din = ovr_en ? ovr_val : sdata(req_addr);
            m_st      = 0;
          end
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_ok(input int ch, input int maxc, output bit got);
    got = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      tick();
      if (get_ok(ch)) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_wait_state(output bit got);
    got = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (m_st == 2) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    vec++; if (sdram_req !== 1'b0) begin errs++; $display("FAIL reset_req: got %b, expected 0", sdram_req); end
    vec++; if (sdram_addr !== 22'h0) begin errs++; $display("FAIL reset_addr: got %h, expected 0", sdram_addr); end
    vec++; if (timeout !== 1'b0) begin errs++; $display("FAIL reset_timeout: got %b, expected 0", timeout); end
    vec++; if ({scr1_ok, scr2_ok, obj_ok} !== 3'b000) begin errs++; $display("FAIL reset_ok: got %b, expected 000", {scr1_ok, scr2_ok, obj_ok}); end
    vec++; if ({scr1_data, scr2_data, obj_data} !== 96'h0) begin errs++; $display("FAIL reset_data: got %h, expected 0", {scr1_data, scr2_data, obj_data}); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    bit got;
    int n0;
    ack_dly = 2; dok_dly = 3; ovr_en = 1'b1; ovr_val = 32'hDEADBEEF;
    n0 = nreq;
    exp_q.push_back(S1OFF + 22'h00010);
    scr1_addr = 17'h00010; scr1_cs = 1'b1;
    wait_ok(0, 40, got);
    vec++; if (!got) begin errs++; $display("FAIL single_ok: got 0, expected 1 within 40 cycles"); end
    vec++; if (scr1_data !== 32'hDEADBEEF) begin errs++; $display("FAIL single_data: got %h, expected deadbeef", scr1_data); end
    vec++; if ({scr2_ok, obj_ok} !== 2'b00) begin errs++; $display("FAIL single_other_ok: got %b, expected 00", {scr2_ok, obj_ok}); end
    repeat (20) tick();
    vec++; if (nreq - n0 !== 1) begin errs++; $display("FAIL single_no_rereq: got %0d requests, expected 1", nreq - n0); end
    vec++; if (scr1_ok !== 1'b1) begin errs++; $display("FAIL single_ok_hold: got %b, expected 1", scr1_ok); end
    scr1_cs = 1'b0;
    tick();
    vec++; if (scr1_ok !== 1'b0) begin errs++; $display("FAIL single_ok_drop: got %b, expected 0", scr1_ok); end
    ovr_en = 1'b0;
  endtask

  task automatic test_latency();
    int k;
    ack_dly = 0; dok_dly = 1;
    exp_q.push_back(S2OFF + 22'h00200);
    scr2_addr = 18'h00200; scr2_cs = 1'b1;
    k = 0;
    do begin
      tick();
      k++;
    end while (!scr2_ok && k < 20);
    vec++; if (k !== 4) begin errs++; $display("FAIL latency_cycles: got %0d, expected 4", k); end
    vec++; if (scr2_data !== sdata(S2OFF + 22'h00200)) begin errs++; $display("FAIL latency_data: got %h, expected %h", scr2_data, sdata(S2OFF + 22'h00200)); end
  endtask

  task automatic test_offset_ackdok();
    bit got;
    logic [21:0] e;
    ack_dly = 1; dok_dly = 0;
    e = {4'd0, 18'h3FFFF} + OBOFF;
    exp_q.push_back(e);
    obj_addr = 18'h3FFFF; obj_cs = 1'b1;
    wait_ok(2, 40, got);
    vec++; if (!got) begin errs++; $display("FAIL offset_ok: got 0, expected 1 within 40 cycles"); end
    vec++; if (obj_data !== sdata(e)) begin errs++; $display("FAIL offset_data: got %h, expected %h", obj_data, sdata(e)); end
  endtask

  task automatic test_round_robin();
    bit got;
    ack_dly = 1; dok_dly = 2;
    exp_q.push_back(S1OFF + 22'h00111);
    exp_q.push_back(S2OFF + 22'h00222);
    exp_q.push_back(OBOFF + 22'h00333);
    scr1_addr = 17'h00111; scr2_addr = 18'h00222; obj_addr = 18'h00333;
    scr1_cs = 1'b1; scr2_cs = 1'b1; obj_cs = 1'b1;
    wait_ok(2, 100, got);
    vec++; if (!got) begin errs++; $display("FAIL rr1_obj_ok: got 0, expected 1 within 100 cycles"); end
    vec++; if ({scr1_ok, scr2_ok, obj_ok} !== 3'b111) begin errs++; $display("FAIL rr1_all_ok: got %b, expected 111", {scr1_ok, scr2_ok, obj_ok}); end
    vec++; if (scr2_data !== sdata(S2OFF + 22'h00222)) begin errs++; $display("FAIL rr1_scr2_data: got %h, expected %h", scr2_data, sdata(S2OFF + 22'h00222)); end
    exp_q.push_back(S1OFF + 22'h00444);
    scr1_addr = 17'h00444;
    wait_ok(0, 50, got);
    vec++; if (!got) begin errs++; $display("FAIL rr2_scr1_ok: got 0, expected 1 within 50 cycles"); end
    exp_q.push_back(S2OFF + 22'h00555);
    exp_q.push_back(OBOFF + 22'h00666);
    exp_q.push_back(S1OFF + 22'h00777);
    scr1_addr = 17'h00777; scr2_addr = 18'h00555; obj_addr = 18'h00666;
    wait_ok(1, 100, got);
    vec++; if (!got) begin errs++; $display("FAIL rr3_scr2_ok: got 0, expected 1 within 100 cycles"); end
    vec++; if ({scr1_ok, obj_ok} !== 2'b00) begin errs++; $display("FAIL rr3_own_ok_a: got %b, expected 00", {scr1_ok, obj_ok}); end
    wait_ok(2, 100, got);
    vec++; if (!got) begin errs++; $display("FAIL rr3_obj_ok: got 0, expected 1 within 100 cycles"); end
    vec++; if (scr1_ok !== 1'b0) begin errs++; $display("FAIL rr3_own_ok_b: got %b, expected 0", scr1_ok); end
    wait_ok(0, 100, got);
    vec++; if (!got) begin errs++; $display("FAIL rr3_scr1_ok: got 0, expected 1 within 100 cycles"); end
    vec++; if (obj_data !== sdata(OBOFF + 22'h00666)) begin errs++; $display("FAIL rr3_obj_data: got %h, expected %h", obj_data, sdata(OBOFF + 22'h00666)); end
    vec++; if (scr1_data !== sdata(S1OFF + 22'h00777)) begin errs++; $display("FAIL rr3_scr1_data: got %h, expected %h", scr1_data, sdata(S1OFF + 22'h00777)); end
  endtask

  task automatic test_addr_change();
    bit got;
    bit bad;
    ack_dly = 1; dok_dly = 6;
    exp_q.push_back(S2OFF + 22'h00100);
    exp_q.push_back(S2OFF + 22'h00104);
    scr2_addr = 18'h00100;
    wait_wait_state(got);
    vec++; if (!got) begin errs++; $display("FAIL achg_wait_reached: got 0, expected 1 within 30 cycles"); end
    scr2_addr = 18'h00104;
    bad = 1'b0;
    repeat (8) begin
      tick();
      if (scr2_ok || scr2_data === sdata(S2OFF + 22'h00100)) bad = 1'b1;
    end
    vec++; if (bad !== 1'b0) begin errs++; $display("FAIL achg_discard: got %b, expected 0 (stale word must not be used)", bad); end
    wait_ok(1, 60, got);
    vec++; if (!got) begin errs++; $display("FAIL achg_ok: got 0, expected 1 within 60 cycles"); end
    vec++; if (scr2_data !== sdata(S2OFF + 22'h00104)) begin errs++; $display("FAIL achg_data: got %h, expected %h", scr2_data, sdata(S2OFF + 22'h00104)); end
  endtask

  task automatic test_timeout_edge();
    bit got;
    ack_dly = 1; dok_dly = int'(TOUT_B);
    exp_q.push_back(S1OFF + 22'h000AA);
    scr1_addr = 17'h000AA;
    wait_ok(0, 400, got);
    vec++; if (!got) begin errs++; $display("FAIL tedge_ok: got 0, expected 1 within 400 cycles"); end
    vec++; if (timeout !== 1'b0) begin errs++; $display("FAIL tedge_timeout: got %b, expected 0", timeout); end
    vec++; if (scr1_data !== sdata(S1OFF + 22'h000AA)) begin errs++; $display("FAIL tedge_data: got %h, expected %h", scr1_data, sdata(S1OFF + 22'h000AA)); end
  endtask

  task automatic test_timeout();
    bit got;
    int k;
    ack_dly = 1; dok_en = 1'b0;
    exp_q.push_back(S1OFF + 22'h000BB);
    exp_q.push_back(S1OFF + 22'h000BB);
    scr1_addr = 17'h000BB;
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (sdram_ack) begin
        got = 1'b1;
        break;
      end
    end
    vec++; if (!got) begin errs++; $display("FAIL tout_ack_seen: got 0, expected 1 within 20 cycles"); end
    k = 0;
    do begin
      tick();
      k++;
    end while (!timeout && k < 400);
    vec++; if (k !== int'(TOUT_B) + 1) begin errs++; $display("FAIL tout_cycles: got %0d, expected %0d", k, int'(TOUT_B) + 1); end
    vec++; if (scr1_ok !== 1'b0) begin errs++; $display("FAIL tout_ok_low: got %b, expected 0", scr1_ok); end
    dok_en = 1'b1; dok_dly = 2;
    wait_ok(0, 40, got);
    vec++; if (!got) begin errs++; $display("FAIL tout_retry_ok: got 0, expected 1 within 40 cycles"); end
    vec++; if (scr1_data !== sdata(S1OFF + 22'h000BB)) begin errs++; $display("FAIL tout_retry_data: got %h, expected %h", scr1_data, sdata(S1OFF + 22'h000BB)); end
    vec++; if (timeout !== 1'b1) begin errs++; $display("FAIL tout_sticky: got %b, expected 1", timeout); end
  endtask

  task automatic test_reset_mid();
    bit got;
    ack_dly = 1; dok_dly = 10;
    exp_q.push_back(OBOFF + 22'h000CC);
    obj_addr = 18'h000CC;
    wait_wait_state(got);
    vec++; if (!got) begin errs++; $display("FAIL rmid_wait_reached: got 0, expected 1 within 30 cycles"); end
    rst_n = 1'b0;
    #1;
    vec++; if (sdram_req !== 1'b0) begin errs++; $display("FAIL rmid_req: got %b, expected 0", sdram_req); end
    vec++; if ({scr1_ok, scr2_ok, obj_ok} !== 3'b000) begin errs++; $display("FAIL rmid_ok: got %b, expected 000", {scr1_ok, scr2_ok, obj_ok}); end
    vec++; if (timeout !== 1'b0) begin errs++; $display("FAIL rmid_timeout: got %b, expected 0", timeout); end
    scr2_cs = 1'b0;
    scr1_addr = 17'h0000C;
    exp_q.push_back(S1OFF + 22'h0000C);
    exp_q.push_back(OBOFF + 22'h000CC);
    dok_dly = 2;
    repeat (2) tick();
    rst_n = 1'b1;
    wait_ok(2, 60, got);
    vec++; if (!got) begin errs++; $display("FAIL rmid_obj_ok: got 0, expected 1 within 60 cycles"); end
    vec++; if (scr1_ok !== 1'b1) begin errs++; $display("FAIL rmid_scr1_first: got %b, expected 1", scr1_ok); end
    vec++; if (obj_data !== sdata(OBOFF + 22'h000CC)) begin errs++; $display("FAIL rmid_obj_data: got %h, expected %h", obj_data, sdata(OBOFF + 22'h000CC)); end
  endtask

  task automatic test_final();
    repeat (10) tick();
    vec++; if (exp_q.size() !== 0) begin errs++; $display("FAIL sb_leftover: got %0d outstanding, expected 0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_latency();
    test_offset_ackdok();
    test_round_robin();
    test_addr_change();
    test_timeout_edge();
    test_timeout();
    test_reset_mid();
    test_final();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within 200000 ns");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
